// File: rtl/branch_resolver.sv
// Branch/jump resolution sequencer: evaluates one control transfer at a time, flags
// faults, raises a held redirect on mispredict, and owns the 2-bit-counter BHT.
module branch_resolver #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_IDX_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [2:0]      i_funct3,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic            i_pred_taken,
  output logic            o_done,
  output logic            o_taken,
  output logic            o_illegal,
  output logic            o_misaligned,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  input  logic            i_redirect_ack,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_lookup_taken
);

  localparam int unsigned BhtEntries = 1 << BHT_IDX_W;

  typedef enum logic [1:0] {StIdle, StResolve, StRedirect} state_e;

  state_e                state_q;
  logic [XLEN-1:0]       pc_q, rs1_q, rs2_q, imm_q, redirect_pc_q;
  logic [2:0]            funct3_q;
  logic                  is_jal_q, is_jalr_q, pred_q;
  logic [1:0]            bht_q [BhtEntries];

  logic                  cond_true, bad_funct3, is_cond;
  logic                  taken, illegal, misaligned, mispredict, resolving, bht_we;
  logic [XLEN-1:0]       jalr_sum, target, fallthrough;
  logic [BHT_IDX_W-1:0]  upd_idx, lookup_idx;
  logic                  unused_bits;

  // Comparator driven from the registered operands.
  always_comb begin
    cond_true  = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3_q)
      3'b000:  cond_true = (rs1_q == rs2_q);
      3'b001:  cond_true = (rs1_q != rs2_q);
      3'b100:  cond_true = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond_true = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond_true = (rs1_q <  rs2_q);
      3'b111:  cond_true = (rs1_q >= rs2_q);
      default: bad_funct3 = 1'b1;
    endcase
  end

  always_comb begin
    is_cond     = !is_jal_q && !is_jalr_q;
    illegal     = is_cond && bad_funct3;
    taken       = is_jal_q || is_jalr_q || (is_cond && !bad_funct3 && cond_true);
    jalr_sum    = rs1_q + imm_q;
    // JALR takes precedence when both jump flags are set.
    target      = is_jalr_q ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_q);
    fallthrough = pc_q + XLEN'(4);
    misaligned  = taken && target[1];
    mispredict  = (taken != pred_q) || is_jalr_q;
    resolving   = (state_q == StResolve);
    bht_we      = resolving && is_cond && !bad_funct3 && !misaligned;
    upd_idx     = pc_q[BHT_IDX_W+1:2];
    lookup_idx  = i_lookup_pc[BHT_IDX_W+1:2];
  end

  assign o_ready        = (state_q == StIdle);
  assign o_done         = resolving;
  assign o_taken        = resolving && taken;
  assign o_illegal      = resolving && illegal;
  assign o_misaligned   = resolving && misaligned;
  assign o_redirect     = (state_q == StRedirect);
  assign o_redirect_pc  = redirect_pc_q;
  // Reads the stored value, so a same-cycle update is not forwarded.
  assign o_lookup_taken = bht_q[lookup_idx][1];

  assign unused_bits = ^{i_lookup_pc[XLEN-1:BHT_IDX_W+2], i_lookup_pc[1:0], jalr_sum[0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      funct3_q      <= '0;
      is_jal_q      <= 1'b0;
      is_jalr_q     <= 1'b0;
      pred_q        <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (i_valid) begin
            pc_q      <= i_pc;
            rs1_q     <= i_rs1;
            rs2_q     <= i_rs2;
            imm_q     <= i_imm;
            funct3_q  <= i_funct3;
            is_jal_q  <= i_is_jal;
            is_jalr_q <= i_is_jalr;
            pred_q    <= i_pred_taken;
            state_q   <= StResolve;
          end
        end
        StResolve: begin
          if (!illegal && !misaligned && mispredict) begin
            redirect_pc_q <= taken ? target : fallthrough;
            state_q       <= StRedirect;
          end else begin
            state_q <= StIdle;
          end
        end
        StRedirect: begin
          if (i_redirect_ack) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating 2-bit counters, reset to weakly not-taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BhtEntries); i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      if (taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end

endmodule
